sample_writer: RTL and testbench
================================

SAMPLE_WRITER -- requirements
Module: sample_writer

Interface
REQ-001 SHALL have parameters, one per line, as name, default, meaning:
- ADDR_W, 8, sample RAM address width; buffer depth is 2^ADDR_W.
- DATA_W, 16, sample width.
- COUNT_W, 5, frame-length width; matches the fetch unit's count port.

REQ-002 SHALL have ports, one per line, as name, direction, width, meaning:
- ck, in, 1, sole clock; all logic on posedge.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, global enable; when low, all state and outputs hold and in_valid is ignored.
- in_valid, in, 1, one-cycle strobe: in_data holds a new sample.
- in_data, in, DATA_W, signed sample.
- frame_len, in, COUNT_W, samples per frame; also the count passed to fetch.
- we, out, 1, RAM write enable.
- waddr, out, ADDR_W, RAM write address.
- wdata, out, DATA_W, RAM write data.
- start, out, 1, one-cycle fetch start pulse.
- start_addr, out, ADDR_W, first address of the frame to fetch; valid while start=1.
- count, out, COUNT_W, frame length to fetch; valid while start=1.
- fetch_done, in, 1, fetch unit done level; stays high until the next start.
- busy, out, 1, high from start until the fetch completes.
- overflow, out, 1, sticky: a frame was dropped.
- wr_ptr, out, ADDR_W, next RAM address to be written.

Function
REQ-003 SHALL register writes: in_valid=1 at edge N gives we=1, waddr=wr_ptr(N), wdata=in_data(N) during cycle N+1; we=0 otherwise.
REQ-004 SHALL increment wr_ptr by 1 per accepted sample, wrapping 2^ADDR_W-1 -> 0 with no full or empty condition; the buffer is circular and always overwrites.
REQ-005 SHALL keep a sample counter cleared at each frame completion; a frame completes on the accepted sample that brings the counter to frame_len.
REQ-006 SHALL latch frame_len at each frame completion; a change mid-frame applies to the counter comparison immediately.
REQ-007 SHALL treat frame_len=0 as disabled: no frames complete and the counter holds at 0.
REQ-008 SHALL define the frame address as (wr_ptr after increment - latched frame_len) mod 2^ADDR_W, i.e. the oldest sample of the frame, including across wrap.
REQ-009 SHALL implement FSM states IDLE, ARM, WAIT.
- IDLE: on frame completion -> ARM.
- ARM: one cycle; start=1, start_addr=frame address, count=latched frame_len; -> WAIT.
- ARM is entered one cycle after the last sample's strobe, so that sample's RAM write completes in the same cycle as start.
REQ-010 In WAIT, SHALL detect the fetch_done rising edge (registered previous value) rather than the level, because done is still high from the previous fetch while start is pulsed.
REQ-011 On a fetch_done rising edge in WAIT: -> IDLE if no frame is pending, else -> ARM using the pending frame address.
REQ-012 SHALL keep writing samples and counting frames in ARM and WAIT.
REQ-013 SHALL hold a one-deep pending slot for a frame completing in WAIT.
- A second completion while pending=1 replaces the pending address with the newest frame and sets overflow=1.
REQ-014 On frame completion in the same cycle as the fetch_done rising edge, SHALL take the new frame straight to ARM; it is not counted as overflow.
REQ-015 busy SHALL be 1 in ARM and WAIT, 0 in IDLE.
REQ-016 overflow SHALL clear only on rst.

Reset
REQ-017 On rst assertion, asynchronously and independent of en:
- we=0, waddr=0, wdata=0, start=0, start_addr=0, count=0, busy=0, overflow=0, wr_ptr=0.
- FSM -> IDLE; sample counter, pending flag and fetch_done history cleared.
REQ-018 rst asserted mid-fetch SHALL abandon the frame; the next frame completes after frame_len new samples written from address 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then 12 strobes of 0x0001..0x000C with frame_len=12 -> RAM[0..11]=1..12; one start pulse 1 cycle after the 12th strobe with start_addr=0, count=12; busy=1.
- Pre-load wr_ptr to 250 (250 samples with frame_len=0), set frame_len=12, feed 12 samples -> writes to 250..255 then 0..5; start_addr=250; wr_ptr=6.
- During WAIT, 12 more samples then fetch_done 0->1 -> second start on the cycle after the edge with start_addr=12; overflow=0.
- During WAIT, 24 more samples with no done -> overflow=1; the start after done has start_addr=24.
- fetch_done held high from the prior fetch when start pulses -> no early IDLE; exit only on a fresh 0->1 edge.
- Assert rst for 1 cycle in WAIT -> all outputs at reset values immediately; no start until 12 new samples.

Source files
------------

// File: rtl/sample_writer.sv
// sample_writer: circular sample-buffer writer that hands completed frames
// to a fetch unit, with one frame of queueing behind an active fetch.
module sample_writer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int COUNT_W = 5
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic [COUNT_W-1:0]        frame_len,
    output logic                      we,
    output logic [ADDR_W-1:0]         waddr,
    output logic signed [DATA_W-1:0]  wdata,
    output logic                      start,
    output logic [ADDR_W-1:0]         start_addr,
    output logic [COUNT_W-1:0]        count,
    input  logic                      fetch_done,
    output logic                      busy,
    output logic                      overflow,
    output logic [ADDR_W-1:0]         wr_ptr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                     r_we;
    logic [ADDR_W-1:0]        r_waddr;
    logic signed [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [COUNT_W-1:0]       r_cnt;
    logic [ADDR_W-1:0]        r_cur_addr;
    logic [COUNT_W-1:0]       r_cur_cnt;
    logic                     r_pend;
    logic [ADDR_W-1:0]        r_pend_addr;
    logic [COUNT_W-1:0]       r_pend_cnt;
    logic                     r_ovf;
    logic                     r_done_q;

    logic                     w_acc;
    logic                     w_len_on;
    logic [COUNT_W:0]         w_cnt_nx;
    logic                     w_fr_done;
    logic                     w_rise;
    logic [ADDR_W-1:0]        w_ptr_inc;
    logic [ADDR_W-1:0]        w_faddr;
    logic                     w_load_new;
    logic                     w_load_pend;
    logic                     w_set_pend;
    logic                     w_clr_pend;
    logic                     w_set_ovf;
    logic                     w_start;
    logic                     w_busy;

    assign w_acc     = en & in_valid;
    assign w_len_on  = |frame_len;
    assign w_cnt_nx  = {1'b0, r_cnt} + (COUNT_W+1)'(1);
    // >= rather than == so a mid-frame shrink below the count still closes
    assign w_fr_done = w_acc & w_len_on & (w_cnt_nx >= {1'b0, frame_len});
    assign w_rise    = fetch_done & ~r_done_q;
    assign w_ptr_inc = r_wr_ptr + ADDR_W'(1);
    assign w_faddr   = w_ptr_inc - ADDR_W'(frame_len);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load_new  = 1'b0;
        w_load_pend = 1'b0;
        w_set_pend  = 1'b0;
        w_clr_pend  = 1'b0;
        w_set_ovf   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fr_done) begin
                    w_next     = S_ARM;
                    w_load_new = 1'b1;
                end
            end
            S_ARM: begin
                w_next = S_WAIT;
                if (w_fr_done) begin
                    w_set_pend = 1'b1;
                    w_set_ovf  = r_pend;
                end
            end
            S_WAIT: begin
                if (w_rise) begin
                    if (w_fr_done) begin
                        w_next     = S_ARM;
                        w_load_new = 1'b1;
                        w_clr_pend = 1'b1;
                        w_set_ovf  = r_pend;
                    end else if (r_pend) begin
                        w_next      = S_ARM;
                        w_load_pend = 1'b1;
                        w_clr_pend  = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else if (w_fr_done) begin
                    w_set_pend = 1'b1;
                    w_set_ovf  = r_pend;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_busy  = 1'b0;
        unique case (r_state)
            S_ARM: begin
                w_start = 1'b1;
                w_busy  = 1'b1;
            end
            S_WAIT: begin
                w_busy = 1'b1;
            end
            default: begin
                w_start = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wr_ptr <= '0;
            r_done_q <= 1'b0;
        end else if (en) begin
            r_we     <= in_valid;
            r_done_q <= fetch_done;
            if (in_valid) begin
                r_waddr  <= r_wr_ptr;
                r_wdata  <= in_data;
                r_wr_ptr <= w_ptr_inc;
            end
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            if (!w_len_on || w_fr_done) begin
                r_cnt <= '0;
            end else if (w_acc) begin
                r_cnt <= w_cnt_nx[COUNT_W-1:0];
            end
        end
    end

    // Each frame slot carries its own length, captured at completion
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_cur_addr  <= '0;
            r_cur_cnt   <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pend_cnt  <= '0;
            r_ovf       <= 1'b0;
        end else if (en) begin
            if (w_load_new) begin
                r_cur_addr <= w_faddr;
                r_cur_cnt  <= frame_len;
            end else if (w_load_pend) begin
                r_cur_addr <= r_pend_addr;
                r_cur_cnt  <= r_pend_cnt;
            end
            if (w_set_pend) begin
                r_pend      <= 1'b1;
                r_pend_addr <= w_faddr;
                r_pend_cnt  <= frame_len;
            end else if (w_clr_pend) begin
                r_pend <= 1'b0;
            end
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign start      = w_start;
    assign start_addr = r_cur_addr;
    assign count      = r_cur_cnt;
    assign busy       = w_busy;
    assign overflow   = r_ovf;
    assign wr_ptr     = r_wr_ptr;

endmodule

// File: tb/tb_sample_writer.sv
// tb_sample_writer: directed bench for sample_writer with a frame-queue
// model checked every cycle plus hand-computed spot values.
module tb_sample_writer;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int CW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          ck;
    logic          t_rst;
    logic          t_en;
    logic          t_v;
    logic [DW-1:0] t_d;
    logic [CW-1:0] t_fl;
    logic          t_fd;

    logic          d_we;
    logic [AW-1:0] d_waddr;
    logic [DW-1:0] d_wdata;
    logic          d_start;
    logic [AW-1:0] d_sa;
    logic [CW-1:0] d_cnt;
    logic          d_busy;
    logic          d_ovf;
    logic [AW-1:0] d_ptr;

    int n_chk;
    int n_fail;
    bit m_chk;

    int m_ptr;
    int m_cnt;
    bit m_busy;
    bit m_fd_prev;
    int q_addr[$];
    int q_cnt[$];
    bit e_we;
    int e_waddr;
    int e_wdata;
    bit e_start;
    int e_sa;
    int e_cnt;
    bit e_ovf;

    logic [DW-1:0] ram [DEPTH];

    sample_writer #(.ADDR_W(AW), .DATA_W(DW), .COUNT_W(CW)) dut (
        .ck(ck), .rst(t_rst), .en(t_en), .in_valid(t_v), .in_data(t_d),
        .frame_len(t_fl), .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
        .start(d_start), .start_addr(d_sa), .count(d_cnt),
        .fetch_done(t_fd), .busy(d_busy), .overflow(d_ovf), .wr_ptr(d_ptr)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    always @(posedge ck) begin
        if (d_we === 1'b1) ram[d_waddr] <= d_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_busy = 0; m_fd_prev = 0;
        q_addr.delete(); q_cnt.delete();
        e_we = 0; e_waddr = 0; e_wdata = 0; e_start = 0;
        e_sa = 0; e_cnt = 0; e_ovf = 0;
    endtask

    // Frames queue up for the fetch unit; only the newest waiting one survives
    task automatic model_step();
        bit was_arm;
        bit rise;
        if (!t_en) return;
        was_arm = e_start;
        e_start = 0;
        e_we = t_v;
        rise = t_fd && !m_fd_prev;
        m_fd_prev = t_fd;
        if (m_busy && !was_arm && rise) m_busy = 0;
        if (t_v) begin
            e_waddr = m_ptr;
            e_wdata = int'(t_d);
            m_ptr = (m_ptr + 1) % DEPTH;
            if (t_fl != 0) begin
                m_cnt++;
                if (m_cnt >= int'(t_fl)) begin
                    q_addr.push_back((m_ptr - int'(t_fl) + DEPTH) % DEPTH);
                    q_cnt.push_back(int'(t_fl));
                    m_cnt = 0;
                    if (q_addr.size() > 1) begin
                        void'(q_addr.pop_front());
                        void'(q_cnt.pop_front());
                        e_ovf = 1;
                    end
                end
            end
        end
        if (t_fl == 0) m_cnt = 0;
        if (!m_busy && q_addr.size() > 0) begin
            e_start = 1;
            e_sa = q_addr.pop_front();
            e_cnt = q_cnt.pop_front();
            m_busy = 1;
        end
    endtask

    always @(negedge ck) begin
        if (m_chk) begin
            chk("we", 32'(d_we), 32'(e_we));
            chk("waddr", 32'(d_waddr), e_waddr);
            chk("wdata", 32'(d_wdata), e_wdata);
            chk("start", 32'(d_start), 32'(e_start));
            chk("start_addr", 32'(d_sa), e_sa);
            chk("count", 32'(d_cnt), e_cnt);
            chk("busy", 32'(d_busy), 32'(m_busy));
            chk("overflow", 32'(d_ovf), 32'(e_ovf));
            chk("wr_ptr", 32'(d_ptr), m_ptr);
        end
    end

    task automatic cyc(input bit e, input bit v, input logic [DW-1:0] d);
        t_en = e; t_v = v; t_d = d;
        @(posedge ck);
        model_step();
        @(negedge ck);
    endtask

    task automatic do_reset();
        #2;
        t_v = 0;
        t_rst = 1;
        model_reset();
        #1;
        chk("rst_we", 32'(d_we), 0);
        chk("rst_waddr", 32'(d_waddr), 0);
        chk("rst_wdata", 32'(d_wdata), 0);
        chk("rst_start", 32'(d_start), 0);
        chk("rst_start_addr", 32'(d_sa), 0);
        chk("rst_count", 32'(d_cnt), 0);
        chk("rst_busy", 32'(d_busy), 0);
        chk("rst_overflow", 32'(d_ovf), 0);
        chk("rst_wr_ptr", 32'(d_ptr), 0);
        @(posedge ck);
        @(negedge ck);
        #2;
        t_rst = 0;
    endtask

    initial begin
        int acc;
        int i;
        n_chk = 0; n_fail = 0; m_chk = 0;
        t_rst = 0; t_en = 1; t_v = 0; t_d = '0; t_fl = 5'd12; t_fd = 0;
        model_reset();
        @(negedge ck);
        do_reset();
        m_chk = 1;

        // A: first frame, then a queued frame, then held-high done
        for (int k = 1; k <= 12; k++) cyc(1, 1, 16'(k));
        chk("s1_start", 32'(d_start), 1);
        chk("s1_start_addr", 32'(d_sa), 0);
        chk("s1_count", 32'(d_cnt), 12);
        chk("s1_busy", 32'(d_busy), 1);
        chk("s1_last_waddr", 32'(d_waddr), 11);
        chk("s1_last_wdata", 32'(d_wdata), 12);
        cyc(1, 0, '0);
        chk("s1_start_gone", 32'(d_start), 0);
        for (int k = 0; k < 12; k++) chk("s1_ram", 32'(ram[k]), k + 1);
        for (int k = 13; k <= 24; k++) cyc(1, 1, 16'(k));
        chk("s3_no_start", 32'(d_start), 0);
        t_fd = 1;
        cyc(1, 0, '0);
        chk("s3_start", 32'(d_start), 1);
        chk("s3_start_addr", 32'(d_sa), 12);
        chk("s3_overflow", 32'(d_ovf), 0);
        for (int k = 0; k < 4; k++) cyc(1, 0, '0);
        chk("s5_busy_held", 32'(d_busy), 1);
        t_fd = 0;
        cyc(1, 0, '0);
        cyc(1, 0, '0);
        chk("s5_busy_low", 32'(d_busy), 1);
        t_fd = 1;
        cyc(1, 0, '0);
        chk("s5_idle", 32'(d_busy), 0);

        // B: overflow while waiting, then reset mid-fetch
        t_fd = 0;
        do_reset();
        for (int k = 1; k <= 12; k++) cyc(1, 1, 16'(k));
        for (int k = 13; k <= 36; k++) cyc(1, 1, 16'(k));
        chk("s4_overflow", 32'(d_ovf), 1);
        chk("s4_busy", 32'(d_busy), 1);
        t_fd = 1;
        cyc(1, 0, '0);
        chk("s4_start", 32'(d_start), 1);
        chk("s4_start_addr", 32'(d_sa), 24);
        chk("s4_count", 32'(d_cnt), 12);
        cyc(1, 0, '0);
        cyc(1, 0, '0);
        do_reset();
        for (int k = 1; k <= 11; k++) cyc(1, 1, 16'(16'h40 + k));
        chk("s6_no_start", 32'(d_start), 0);
        cyc(1, 1, 16'h4c);
        chk("s6_start", 32'(d_start), 1);
        chk("s6_start_addr", 32'(d_sa), 0);
        chk("s6_wr_ptr", 32'(d_ptr), 12);

        // C: preload with frames disabled, some cycles with en low
        t_fd = 0;
        t_fl = 5'd0;
        do_reset();
        acc = 0;
        i = 0;
        while (acc < 250) begin
            bit e;
            e = (i % 17) != 3;
            cyc(e, 1, 16'(i));
            if (e) acc++;
            i++;
        end
        chk("s2_preload_ptr", 32'(d_ptr), 250);
        chk("s2_preload_busy", 32'(d_busy), 0);
        t_fl = 5'd12;
        for (int k = 0; k < 12; k++) cyc(1, 1, 16'(16'h100 + k));
        chk("s2_start", 32'(d_start), 1);
        chk("s2_start_addr", 32'(d_sa), 250);
        chk("s2_count", 32'(d_cnt), 12);
        chk("s2_wr_ptr", 32'(d_ptr), 6);
        cyc(1, 0, '0);
        for (int k = 0; k < 12; k++)
            chk("s2_ram", 32'(ram[(250 + k) % DEPTH]), 32'h100 + k);

        // D: frame completes on the same edge the fetch finishes
        for (int k = 0; k < 11; k++) cyc(1, 1, 16'(16'h200 + k));
        t_fd = 1;
        cyc(1, 1, 16'h20b);
        chk("s14_start", 32'(d_start), 1);
        chk("s14_start_addr", 32'(d_sa), 6);
        chk("s14_overflow", 32'(d_ovf), 0);
        cyc(1, 0, '0);
        cyc(1, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
